alignment_controller: RTL

Host-facing sequencer for the N×M alignment processing grid.
- Holds the scoring configuration and both input sequences in registers.
- On command, clears and starts the grid, then waits for its finish flag, with a cycle timeout.
- Returns the score through a valid/ready result handshake, with a cycle count and a timeout flag.

---
 rtl/alignment_pkg.sv | 42 ++++
 rtl/alignment_cfg_regs.sv | 115 +++++++++++
 rtl/alignment_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alignment_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alignment_pkg
//  Description : Shared types and constants for the alignment controller:
//                FSM state encoding, config-bus address layout, bank codes,
//                scalar register indices and default scoring values.
//  Revision    : 1.0 - initial release
// ============================================================================
package alignment_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // 8-bit config address: [7:6] bank, [5:0] index
    localparam int ADDR_W        = 8;
    localparam int ADDR_BANK_MSB = 7;
    localparam int ADDR_BANK_LSB = 6;
    localparam int ADDR_IDX_W    = 6;

    // Bank codes
    localparam logic [1:0] BANK_SCALAR = 2'b00;
    localparam logic [1:0] BANK_SEQA   = 2'b01;
    localparam logic [1:0] BANK_SEQB   = 2'b10;
    localparam logic [1:0] BANK_RSVD   = 2'b11;

    // Scalar bank indices
    localparam logic [5:0] IDX_MATCH    = 6'd0;
    localparam logic [5:0] IDX_MISMATCH = 6'd1;
    localparam logic [5:0] IDX_GAP      = 6'd2;

    // Scoring defaults applied at reset
    localparam int DEF_MATCH    = 1;
    localparam int DEF_MISMATCH = 0;
    localparam int DEF_GAP      = 0;

endpackage : alignment_pkg
`default_nettype wire

// File: rtl/alignment_cfg_regs.sv
`default_nettype none
// ============================================================================
//  Module      : alignment_cfg_regs
//  Description : Config register file for the alignment controller. Decodes
//                bank/index, range-checks the index, stores the scoring
//                scalars and both symbol sequences, and pulses cfg_err one
//                cycle after any rejected write.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                wr_en             - raw write strobe
//                wr_allow          - writes permitted (controller idle)
//                wr_addr, wr_data  - write address and data
//                cfg_err           - rejected-write pulse
//                match_score, mismatch_penalty, gap_penalty - scalars
//                seq_a, seq_b      - packed symbol sequences
//  Revision    : 1.0 - initial release
// ============================================================================
module alignment_cfg_regs
    import alignment_pkg::*;
#(
    parameter int N       = 29,
    parameter int M       = 29,
    parameter int SYM_W   = 8,
    parameter int SCORE_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_allow,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [SCORE_W-1:0]   wr_data,
    output logic                 cfg_err,
    output logic [SCORE_W-1:0]   match_score,
    output logic [SCORE_W-1:0]   mismatch_penalty,
    output logic [SCORE_W-1:0]   gap_penalty,
    output logic [N*SYM_W-1:0]   seq_a,
    output logic [M*SYM_W-1:0]   seq_b
);

    logic [1:0]            w_bank;
    logic [ADDR_IDX_W-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_accept;

    logic                  r_err;
    logic [SCORE_W-1:0]    r_match;
    logic [SCORE_W-1:0]    r_mismatch;
    logic [SCORE_W-1:0]    r_gap;
    logic [N*SYM_W-1:0]    r_seq_a;
    logic [M*SYM_W-1:0]    r_seq_b;

    assign w_bank = wr_addr[ADDR_BANK_MSB:ADDR_BANK_LSB];
    assign w_idx  = wr_addr[ADDR_IDX_W-1:0];

    always_comb begin
        w_in_range = 1'b0;
        case (w_bank)
            BANK_SCALAR: w_in_range = (w_idx <= IDX_GAP);
            BANK_SEQA:   w_in_range = (int'(w_idx) < N);
            BANK_SEQB:   w_in_range = (int'(w_idx) < M);
            default:     w_in_range = 1'b0;
        endcase
    end

    assign w_accept = wr_en & wr_allow & w_in_range;

    // Any strobe that is not accepted is an error, whatever the reason
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= wr_en & ~(wr_allow & w_in_range);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_match    <= SCORE_W'(DEF_MATCH);
            r_mismatch <= SCORE_W'(DEF_MISMATCH);
            r_gap      <= SCORE_W'(DEF_GAP);
        end else if (w_accept && (w_bank == BANK_SCALAR)) begin
            case (w_idx)
                IDX_MATCH:    r_match    <= wr_data;
                IDX_MISMATCH: r_mismatch <= wr_data;
                IDX_GAP:      r_gap      <= wr_data;
                default:      r_gap      <= r_gap;
            endcase
        end
    end

    // Index is range-checked by w_accept, so the part-select stays in bounds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_a <= '0;
        end else if (w_accept && (w_bank == BANK_SEQA)) begin
            r_seq_a[int'(w_idx)*SYM_W +: SYM_W] <= wr_data[SYM_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_b <= '0;
        end else if (w_accept && (w_bank == BANK_SEQB)) begin
            r_seq_b[int'(w_idx)*SYM_W +: SYM_W] <= wr_data[SYM_W-1:0];
        end
    end

    assign cfg_err          = r_err;
    assign match_score      = r_match;
    assign mismatch_penalty = r_mismatch;
    assign gap_penalty      = r_gap;
    assign seq_a            = r_seq_a;
    assign seq_b            = r_seq_b;

endmodule : alignment_cfg_regs
`default_nettype wire

// File: rtl/alignment_controller.sv
`default_nettype none
// ============================================================================
//  Module      : alignment_controller
//  Description : Host-facing sequencer for the NxM alignment grid. Holds the
//                scoring config and sequences, clears and starts the grid on
//                command, waits for grid_finish with a cycle timeout and
//                returns the result over a valid/ready handshake.
//  Ports       : clk, reset                    - clock, sync active-high reset
//                cfg_we/cfg_addr/cfg_wdata     - config write bus
//                cfg_err                       - rejected-write pulse
//                cmd_start, busy               - run request / status
//                res_valid/res_ready/res_*     - result handshake
//                grid_reset/grid_start         - grid sequencing
//                grid_finish/grid_solution     - grid completion and score
//                match_score..seq_b            - config to the grid
//  Revision    : 1.0 - initial release
// ============================================================================
module alignment_controller
    import alignment_pkg::*;
#(
    parameter int N          = 29,
    parameter int M          = 29,
    parameter int SYM_W      = 8,
    parameter int SCORE_W    = 32,
    parameter int TIMEOUT    = 1024,
    parameter int CLR_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [SCORE_W-1:0]   cfg_wdata,
    output logic                 cfg_err,
    input  logic                 cmd_start,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SCORE_W-1:0]   res_score,
    output logic [CNT_W-1:0]     res_cycles,
    output logic                 res_timeout,
    output logic                 grid_reset,
    output logic                 grid_start,
    input  logic                 grid_finish,
    input  logic [SCORE_W-1:0]   grid_solution,
    output logic [SCORE_W-1:0]   match_score,
    output logic [SCORE_W-1:0]   mismatch_penalty,
    output logic [SCORE_W-1:0]   gap_penalty,
    output logic [N*SYM_W-1:0]   seq_a,
    output logic [M*SYM_W-1:0]   seq_b
);

    localparam int                c_clr_w    = $clog2(CLR_CYCLES + 1);
    localparam logic [c_clr_w-1:0] c_clr_last = c_clr_w'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_timeout  = CNT_W'(TIMEOUT);

    state_t               r_state;
    logic [c_clr_w-1:0]   r_clr_cnt;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_grid_start;
    logic                 r_res_valid;
    logic [SCORE_W-1:0]   r_res_score;
    logic [CNT_W-1:0]     r_res_cycles;
    logic                 r_res_timeout;

    logic                 w_idle;
    logic [CNT_W-1:0]     w_cnt_next;

    assign w_idle     = (r_state == ST_IDLE);
    // Count including the current RUN cycle
    assign w_cnt_next = r_cnt + CNT_W'(1);

    alignment_cfg_regs #(
        .N       (N),
        .M       (M),
        .SYM_W   (SYM_W),
        .SCORE_W (SCORE_W)
    ) u_cfg_regs (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (cfg_we),
        .wr_allow         (w_idle),
        .wr_addr          (cfg_addr),
        .wr_data          (cfg_wdata),
        .cfg_err          (cfg_err),
        .match_score      (match_score),
        .mismatch_penalty (mismatch_penalty),
        .gap_penalty      (gap_penalty),
        .seq_a            (seq_a),
        .seq_b            (seq_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_clr_cnt     <= '0;
            r_cnt         <= '0;
            r_grid_start  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_score   <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_state       <= ST_CLEAR;
                        r_clr_cnt     <= '0;
                        r_cnt         <= '0;
                        r_res_valid   <= 1'b0;
                        r_res_timeout <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == c_clr_last) begin
                        r_state      <= ST_RUN;
                        r_grid_start <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
                    end
                end
                ST_RUN: begin
                    r_cnt <= w_cnt_next;
                    // Finish has priority over a coincident timeout
                    if (grid_finish) begin
                        r_res_score   <= grid_solution;
                        r_res_cycles  <= w_cnt_next;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_grid_start  <= 1'b0;
                        r_state       <= ST_DONE;
                    end else if (w_cnt_next == c_timeout) begin
                        r_res_score   <= '0;
                        r_res_cycles  <= c_timeout;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_grid_start  <= 1'b0;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Grid is held in reset both by the system reset and during CLEAR
    assign grid_reset  = reset | (r_state == ST_CLEAR);
    assign grid_start  = r_grid_start;
    assign busy        = ~w_idle;
    assign res_valid   = r_res_valid;
    assign res_score   = r_res_score;
    assign res_cycles  = r_res_cycles;
    assign res_timeout = r_res_timeout;

endmodule : alignment_controller
`default_nettype wire
